proj_bottomk_stream: RTL and testbench

Streaming bottom-k selector for the MinHash signature path. It accepts one (signature, index) pair per cycle over a valid/ready handshake and keeps the K smallest signatures of the current set in an ascending, sorted insertion array. When the set ends, it streams the retained entries out in ascending signature order, then clears itself for the next set. It sits between the hash-signature generator and the sketch writer, and replaces the unsorted, non-framed top-K register bank.

---
 rtl/proj_pkg.sv | 34 +++
 rtl/proj_sorter_cell.sv | 109 ++++++++++
 rtl/proj_bottomk_stream.sv | 190 +++++++++++++++++++
 tb/tb_proj_bottomk_stream.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// ---------------------------------------------------------------------------
// proj_pkg
// Shared types and default sizes for the streaming bottom-k selector.
//   sorter_state_t : top-level FSM states (ACCEPT while collecting a set,
//                    EMIT while streaming the retained entries out).
//   sorter_entry_t : one retained slot {vld, sig, idx} at the default widths.
//   cell_op_t      : per-slot update selection used inside proj_sorter_cell.
// No ports; imported by proj_sorter_cell and proj_bottomk_stream.
// ---------------------------------------------------------------------------
package proj_pkg;

    localparam int unsigned DEFAULT_INDICES_COUNT = 4;
    localparam int unsigned DEFAULT_INDICE_LEN    = 8;
    localparam int unsigned DEFAULT_SIGNATURE_LEN = 32;

    typedef enum logic {
        ACCEPT = 1'b0,
        EMIT   = 1'b1
    } sorter_state_t;

    typedef struct packed {
        logic                             vld;
        logic [DEFAULT_SIGNATURE_LEN-1:0] sig;
        logic [DEFAULT_INDICE_LEN-1:0]    idx;
    } sorter_entry_t;

    typedef enum logic [1:0] {
        CELL_HOLD  = 2'd0,
        CELL_LOAD  = 2'd1,
        CELL_LEFT  = 2'd2,
        CELL_RIGHT = 2'd3
    } cell_op_t;

endpackage

// File: rtl/proj_sorter_cell.sv
// ---------------------------------------------------------------------------
// proj_sorter_cell
// One slot of the sorted insertion array. Each cell compares the incoming
// signature against its own entry and, together with its left neighbour's
// compare bit, decides whether to hold, load the new beat, take the left
// neighbour's entry (shift up on insert) or take the right neighbour's entry
// (shift down on emit).
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   clear                      : return the slot to its empty value
//   insert_en                  : an accepted beat is being inserted this cycle
//   shift_en                   : the array drains by one position this cycle
//   in_sig, in_idx             : incoming beat
//   left_less                  : compare bit of the slot below (0 for slot 0)
//   left_vld/sig/idx           : entry of the slot below
//   right_vld/sig/idx          : entry of the slot above (empty for last slot)
//   less                       : incoming beat belongs at or before this slot
//   eq                         : this slot holds a valid equal signature
//   vld, sig, idx              : current slot contents
// ---------------------------------------------------------------------------
module proj_sorter_cell
    import proj_pkg::*;
#(
    parameter int SIG_W = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             insert_en,
    input  logic             shift_en,
    input  logic [SIG_W-1:0] in_sig,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             left_less,
    input  logic             left_vld,
    input  logic [SIG_W-1:0] left_sig,
    input  logic [IDX_W-1:0] left_idx,
    input  logic             right_vld,
    input  logic [SIG_W-1:0] right_sig,
    input  logic [IDX_W-1:0] right_idx,
    output logic             less,
    output logic             eq,
    output logic             vld,
    output logic [SIG_W-1:0] sig,
    output logic [IDX_W-1:0] idx
);

    logic             vld_q, vld_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cell_op_t         op;

    // Strict greater-than keeps equal signatures ahead of the new beat, which
    // makes insertion stable. Empty slots always accept. Because the valid
    // entries form a sorted prefix, the less bits across the array read
    // 0..0 1..1, so the first set bit is the insertion point.
    always_comb begin
        less = !vld_q || (in_sig < sig_q);
        eq   = vld_q && (in_sig == sig_q);

        op = CELL_HOLD;
        if (shift_en) begin
            op = CELL_RIGHT;
        end else if (insert_en && less) begin
            op = left_less ? CELL_LEFT : CELL_LOAD;
        end

        vld_d = vld_q;
        sig_d = sig_q;
        idx_d = idx_q;
        case (op)
            CELL_LOAD: begin
                vld_d = 1'b1;
                sig_d = in_sig;
                idx_d = in_idx;
            end
            CELL_LEFT: begin
                vld_d = left_vld;
                sig_d = left_sig;
                idx_d = left_idx;
            end
            CELL_RIGHT: begin
                vld_d = right_vld;
                sig_d = right_sig;
                idx_d = right_idx;
            end
            default: ;
        endcase
    end

    // Empty slot value is all-ones signature with vld low; vld alone marks
    // occupancy so an all-ones signature is still storable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vld_q <= 1'b0;
            sig_q <= '1;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            sig_q <= sig_d;
            idx_q <= idx_d;
        end
    end

    assign vld = vld_q;
    assign sig = sig_q;
    assign idx = idx_q;

endmodule

// File: rtl/proj_bottomk_stream.sv
// ---------------------------------------------------------------------------
// proj_bottomk_stream
// Streaming bottom-k selector. Collects one (signature, index) beat per cycle,
// keeps the INDICES_COUNT smallest signatures in an ascending array, and on
// the last beat of a set streams them out smallest first, then clears.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : input handshake
//   in_signature, in_index, in_last: input beat, in_last marks end of set
//   out_valid/out_ready            : output handshake
//   out_signature, out_index       : current output entry (slot 0)
//   out_rank                       : position of the entry, 0 = smallest
//   out_last                       : final entry of the set
// Build option: define PROJ_SORTER_DEDUP_EN to drop beats whose signature
// already sits in a valid slot (the handshake still completes).
// ---------------------------------------------------------------------------
module proj_bottomk_stream
    import proj_pkg::*;
#(
    parameter int INDICES_COUNT = DEFAULT_INDICES_COUNT,
    parameter int INDICE_LEN    = DEFAULT_INDICE_LEN,
    parameter int SIGNATURE_LEN = DEFAULT_SIGNATURE_LEN
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SIGNATURE_LEN-1:0]         in_signature,
    input  logic [INDICE_LEN-1:0]            in_index,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SIGNATURE_LEN-1:0]         out_signature,
    output logic [INDICE_LEN-1:0]            out_index,
    output logic [$clog2(INDICES_COUNT)-1:0] out_rank,
    output logic                             out_last
);

    localparam int K      = INDICES_COUNT;
    localparam int RANK_W = $clog2(INDICES_COUNT);
    localparam int CNT_W  = $clog2(INDICES_COUNT + 1);

`ifdef PROJ_SORTER_DEDUP_EN
    localparam bit DEDUP_EN = 1'b1;
`else
    localparam bit DEDUP_EN = 1'b0;
`endif

    sorter_state_t           state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [RANK_W-1:0]       rank_q, rank_d;

    logic                    dup_hit;
    logic                    insert_en;
    logic                    shift_en;
    logic                    clear;

    logic [K-1:0]            cell_less;
    logic [K-1:0]            cell_eq;
    logic [K-1:0]            cell_vld;
    logic [SIGNATURE_LEN-1:0] cell_sig [K];
    logic [INDICE_LEN-1:0]   cell_idx [K];

    // Control: inserts only happen while accepting, shifts only while
    // emitting, and the handshake on the last entry wipes the array.
    // A duplicate beat (dedup builds) still completes its handshake and can
    // still close the set; it just never reaches the cells.
    always_comb begin
        dup_hit   = DEDUP_EN && (|cell_eq);
        insert_en = (state_q == ACCEPT) && in_valid && !dup_hit;
        shift_en  = (state_q == EMIT) && out_ready;
        clear     = 1'b0;

        state_d = state_q;
        count_d = count_q;
        rank_d  = rank_q;

        case (state_q)
            ACCEPT: begin
                if (in_valid) begin
                    if (insert_en && (count_q < CNT_W'(K))) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (count_q == CNT_W'(1)) begin
                        clear   = 1'b1;
                        state_d = ACCEPT;
                        count_d = '0;
                        rank_d  = '0;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                        rank_d  = rank_q + RANK_W'(1);
                    end
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    // State, occupancy and emitted-entry counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
            count_q <= '0;
            rank_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rank_q  <= rank_d;
        end
    end

    // Slot array: each cell sees its neighbours' entries; slot 0 has no left
    // neighbour (so it loads the new beat directly) and the last slot pulls
    // in an empty entry when the array drains.
    for (genvar i = 0; i < K; i++) begin : g_cell
        logic                     left_less;
        logic                     left_vld;
        logic [SIGNATURE_LEN-1:0] left_sig;
        logic [INDICE_LEN-1:0]    left_idx;
        logic                     right_vld;
        logic [SIGNATURE_LEN-1:0] right_sig;
        logic [INDICE_LEN-1:0]    right_idx;

        if (i == 0) begin : g_left_edge
            assign left_less = 1'b0;
            assign left_vld  = 1'b0;
            assign left_sig  = '1;
            assign left_idx  = '0;
        end else begin : g_left_link
            assign left_less = cell_less[i-1];
            assign left_vld  = cell_vld[i-1];
            assign left_sig  = cell_sig[i-1];
            assign left_idx  = cell_idx[i-1];
        end

        if (i == K - 1) begin : g_right_edge
            assign right_vld = 1'b0;
            assign right_sig = '1;
            assign right_idx = '0;
        end else begin : g_right_link
            assign right_vld = cell_vld[i+1];
            assign right_sig = cell_sig[i+1];
            assign right_idx = cell_idx[i+1];
        end

        proj_sorter_cell #(
            .SIG_W (SIGNATURE_LEN),
            .IDX_W (INDICE_LEN)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .insert_en (insert_en),
            .shift_en  (shift_en),
            .in_sig    (in_signature),
            .in_idx    (in_index),
            .left_less (left_less),
            .left_vld  (left_vld),
            .left_sig  (left_sig),
            .left_idx  (left_idx),
            .right_vld (right_vld),
            .right_sig (right_sig),
            .right_idx (right_idx),
            .less      (cell_less[i]),
            .eq        (cell_eq[i]),
            .vld       (cell_vld[i]),
            .sig       (cell_sig[i]),
            .idx       (cell_idx[i])
        );
    end

    // Outputs depend on registered state only; data ports read zero outside
    // EMIT so the idle array contents never leak out.
    always_comb begin
        in_ready      = (state_q == ACCEPT);
        out_valid     = (state_q == EMIT);
        out_signature = out_valid ? cell_sig[0] : '0;
        out_index     = out_valid ? cell_idx[0] : '0;
        out_rank      = out_valid ? rank_q : '0;
        out_last      = out_valid && (count_q == CNT_W'(1));
    end

endmodule

// File: tb/tb_proj_bottomk_stream.sv
// ---------------------------------------------------------------------------
// tb_proj_bottomk_stream
// Self-checking bench for proj_bottomk_stream. Each set is pushed through a
// reference model (an ordered list trimmed to K entries) and the drained
// output stream is compared entry by entry. Directed sets cover ordering,
// short sets, ties, back-pressure, mid-emission reset and the all-ones
// signature; random sets follow. Honours PROJ_SORTER_DEDUP_EN.
// ---------------------------------------------------------------------------
module tb_proj_bottomk_stream;

    localparam int K  = 4;
    localparam int IW = 8;
    localparam int SW = 32;
    localparam int RW = $clog2(K);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_signature;
    logic [IW-1:0] in_index;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_signature;
    logic [IW-1:0] out_index;
    logic [RW-1:0] out_rank;
    logic          out_last;

    int checks = 0;
    int errors = 0;
    bit dedup_en;

    logic [SW-1:0] set_sig[$];
    logic [IW-1:0] set_idx[$];
    logic [SW-1:0] exp_sig[$];
    logic [IW-1:0] exp_idx[$];

    proj_bottomk_stream #(
        .INDICES_COUNT (K),
        .INDICE_LEN    (IW),
        .SIGNATURE_LEN (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signature  (in_signature),
        .in_index      (in_index),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_signature (out_signature),
        .out_index     (out_index),
        .out_rank      (out_rank),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    // Hard stop if something wedges beyond every bounded loop.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: keep an ordered list, insert after all entries <= s, trim
    // to the K smallest. Dedup builds drop any signature already retained.
    task automatic modelInsert(input logic [SW-1:0] s, input logic [IW-1:0] ix);
        int pos;
        bit seen;
        seen = 1'b0;
        foreach (exp_sig[i]) if (exp_sig[i] == s) seen = 1'b1;
        if (!(dedup_en && seen)) begin
            pos = exp_sig.size();
            for (int i = 0; i < exp_sig.size(); i++) begin
                if (exp_sig[i] > s) begin
                    pos = i;
                    break;
                end
            end
            exp_sig.insert(pos, s);
            exp_idx.insert(pos, ix);
            if (exp_sig.size() > K) begin
                void'(exp_sig.pop_back());
                void'(exp_idx.pop_back());
            end
        end
    endtask

    // Feed set_sig/set_idx, one beat per cycle; returns at the first
    // negedge after the in_last handshake.
    task automatic sendSet();
        exp_sig.delete();
        exp_idx.delete();
        for (int i = 0; i < set_sig.size(); i++) begin
            @(negedge clk);
            checkOutput("in_ready_accept", in_ready, 1);
            in_valid     = 1'b1;
            in_signature = set_sig[i];
            in_index     = set_idx[i];
            in_last      = (i == set_sig.size() - 1);
            modelInsert(set_sig[i], set_idx[i]);
        end
        @(negedge clk);
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_signature = $urandom;
        in_index     = IW'($urandom);
    endtask

    // stall_mode: 0 = always ready, 1 = random back-pressure,
    // 2 = hold out_ready low for 3 cycles on the second entry.
    task automatic drainAndCheck(input int stall_mode);
        int rank;
        int budget;
        int held;
        int n;
        rank   = 0;
        budget = 0;
        held   = 0;
        n      = exp_sig.size();
        while (rank < n) begin
            if (budget > 200) begin
                checkOutput("drain_timeout", 1, 0);
                break;
            end
            checkOutput("out_valid", out_valid, 1);
            checkOutput("out_signature", out_signature, exp_sig[rank]);
            checkOutput("out_index", out_index, exp_idx[rank]);
            checkOutput("out_rank", out_rank, rank);
            checkOutput("out_last", out_last, (rank == n - 1));
            checkOutput("in_ready_emit", in_ready, 0);
            case (stall_mode)
                1: out_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (rank == 1 && held < 3) begin
                        out_ready = 1'b0;
                        held++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            @(posedge clk);
            if (out_ready) rank++;
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        checkOutput("in_ready_after", in_ready, 1);
        checkOutput("out_valid_after", out_valid, 0);
    endtask

    task automatic applyStimulus(input int stall_mode);
        sendSet();
        drainAndCheck(stall_mode);
    endtask

    task automatic loadSet(input logic [SW-1:0] s0, input int n, input bit ties);
        set_sig.delete();
        set_idx.delete();
        for (int i = 0; i < n; i++) begin
            set_sig.push_back(ties ? s0 : SW'($urandom));
            set_idx.push_back(IW'(i));
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
        checkOutput({tag, "_out_rank"}, out_rank, 0);
        checkOutput({tag, "_out_signature"}, out_signature, 0);
        checkOutput({tag, "_out_index"}, out_index, 0);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
`ifdef PROJ_SORTER_DEDUP_EN
        dedup_en = 1'b1;
`else
        dedup_en = 1'b0;
`endif
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_signature = '0;
        in_index     = '0;
        in_last      = 1'b0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        $display("[TB] set {9,3,7,1,5}");
        set_sig = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
        set_idx = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        applyStimulus(0);

        $display("[TB] short set {20,10}");
        set_sig = '{32'd20, 32'd10};
        set_idx = '{8'd0, 8'd1};
        applyStimulus(0);

        $display("[TB] ties {5,5,5,5,5}");
        loadSet(32'd5, 5, 1'b1);
        applyStimulus(0);

        $display("[TB] back-pressure, back-to-back sets");
        set_sig = '{32'd40, 32'd30, 32'd10, 32'd20};
        set_idx = '{8'd7, 8'd6, 8'd5, 8'd4};
        applyStimulus(2);
        set_sig = '{32'd3, 32'd1};
        set_idx = '{8'd9, 8'd8};
        applyStimulus(0);

        $display("[TB] reset during emission");
        set_sig = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
        set_idx = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        sendSet();
        checkOutput("rst_first_sig", out_signature, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_second_sig", out_signature, 32'd3);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdle("midreset");
        rst = 1'b0;
        set_sig = '{32'd2};
        set_idx = '{8'd0};
        applyStimulus(0);

        $display("[TB] all-ones signature");
        set_sig = '{32'hFFFF_FFFF};
        set_idx = '{8'd0};
        applyStimulus(0);
        set_sig = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        set_idx = '{8'd0, 8'd1, 8'd2};
        applyStimulus(1);

        $display("[TB] random sets");
        for (int s = 0; s < 30; s++) begin
            int n;
            n = $urandom_range(1, 10);
            set_sig.delete();
            set_idx.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: set_sig.push_back(SW'($urandom));
                    1: set_sig.push_back(32'hFFFF_FFFF);
                    default: set_sig.push_back(SW'($urandom_range(0, 12)));
                endcase
                set_idx.push_back(IW'($urandom));
            end
            applyStimulus(s % 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
